// File: rtl/mem_pkg.sv
// Shared definitions for the load/store access unit: operation encodings,
// FSM states, default parameters and small operation classifiers.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_CH_SEL_MSB  = 30;
  localparam int DEF_TIMEOUT_CYC = 15;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Byte accesses can never be misaligned; halfwords need an even address.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and data replication,
// and load byte/halfword extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (op_i)
      OP_SB: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign byteSel = rword_i[{offset_i, 3'b000} +: 8];
  assign halfSel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    rdata_o = rword_i;
    case (op_i)
      OP_LB:   rdata_o = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  rdata_o = {24'h0, byteSel};
      OP_LH:   rdata_o = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  rdata_o = {16'h0, halfSel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store access unit: accepts one aligned operation at a time, drives a
// shared multi-channel memory bus, and returns aligned load data or a timeout.
module mem_access
  import mem_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_SEL_MSB  = DEF_CH_SEL_MSB,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid_i,
  input  logic [3:0]             op_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic                   except_i,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic                   adel_o,
  output logic                   ades_o,
  output logic                   timeout_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [NUM_CH-1:0]      mem_ch_o,
  output logic [31:0]            mem_addr_o,
  output logic [3:0]             mem_be_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [NUM_CH-1:0]      mem_ack_i,
  input  logic [32*NUM_CH-1:0]   mem_rdata_i
);

  localparam int         CH_W    = $clog2(NUM_CH);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  mem_state_e        state_q;
  logic [7:0]        toCnt_q;
  logic [3:0]        op_q;
  logic [1:0]        offset_q;
  logic [29:0]       wordAddr_q;
  logic [CH_W-1:0]   chIdx_q;
  logic [NUM_CH-1:0] chSel_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              timeout_q;

  logic              isIdle, isBusy, isDone;
  logic              opKnown, misaligned, opLive, accept, ackSel;
  logic [CH_W-1:0]   newChIdx;
  logic [NUM_CH-1:0] newChSel;
  logic [31:0]       ackWord;
  logic [3:0]        alignOp;
  logic [1:0]        alignOff;
  logic [3:0]        alignBe;
  logic [31:0]       alignWdata, alignRdata;

  assign isIdle = (state_q == ST_IDLE);
  assign isBusy = (state_q == ST_BUSY);
  assign isDone = (state_q == ST_DONE);

  // The cycle that reports a timeout releases the stalled op instead of retrying it.
  assign opKnown    = op_is_load(op_i) | op_is_store(op_i);
  assign misaligned = op_misaligned(op_i, addr_i[1:0]);
  assign opLive     = !rst && isIdle && !timeout_q && op_valid_i && opKnown && !except_i;
  assign accept     = opLive && !misaligned;

  assign newChIdx = addr_i[CH_SEL_MSB -: CH_W];
  always_comb begin
    newChSel           = '0;
    newChSel[newChIdx] = 1'b1;
  end

  assign ackSel  = |(mem_ack_i & chSel_q);
  assign ackWord = mem_rdata_i[{chIdx_q, 5'b00000} +: 32];

  assign alignOp  = isIdle ? op_i : op_q;
  assign alignOff = isIdle ? addr_i[1:0] : offset_q;

  mem_lane_align u_lane_align (
    .op_i     (alignOp),
    .offset_i (alignOff),
    .wdata_i  (wdata_i),
    .rword_i  (ackWord),
    .be_o     (alignBe),
    .wdata_o  (alignWdata),
    .rdata_o  (alignRdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      toCnt_q    <= 8'd0;
      op_q       <= 4'd0;
      offset_q   <= 2'd0;
      wordAddr_q <= 30'd0;
      chIdx_q    <= '0;
      chSel_q    <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_BUSY;
            toCnt_q    <= 8'd0;
            op_q       <= op_i;
            offset_q   <= addr_i[1:0];
            wordAddr_q <= addr_i[31:2];
            chIdx_q    <= newChIdx;
            chSel_q    <= newChSel;
            be_q       <= alignBe;
            wdata_q    <= alignWdata;
          end
        end
        ST_BUSY: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (ackSel) begin
            state_q <= ST_DONE;
            rdata_q <= op_is_load(op_q) ? alignRdata : 32'd0;
          end else if (toCnt_q == TO_LAST) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            toCnt_q <= toCnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o     = isBusy || accept;
  assign done_o      = isDone;
  assign rdata_o     = isDone ? rdata_q : 32'd0;
  assign adel_o      = opLive && misaligned && op_is_load(op_i);
  assign ades_o      = opLive && misaligned && op_is_store(op_i);
  assign timeout_o   = timeout_q;
  assign mem_req_o   = isBusy;
  assign mem_we_o    = isBusy && op_is_store(op_q);
  assign mem_ch_o    = isBusy ? chSel_q : '0;
  assign mem_addr_o  = isBusy ? {wordAddr_q, 2'b00} : 32'd0;
  assign mem_be_o    = isBusy ? be_q : 4'd0;
  assign mem_wdata_o = isBusy ? wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: loads, stores, misalignment, timeout,
// ack priority, reset during an access and exception discard.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        op_valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        except_i;
  logic        stall_o, done_o, adel_o, ades_o, timeout_o;
  logic [31:0] rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [1:0]  mem_ch_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [1:0]  mem_ack_i;
  logic [63:0] mem_rdata_i;

  int compared   = 0;
  int mismatched = 0;

  mem_access dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_i  (op_valid_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .except_i    (except_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .adel_o      (adel_o),
    .ades_o      (ades_o),
    .timeout_o   (timeout_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_ch_o    (mem_ch_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    compared++;
    if (obs !== expVal) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expVal);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wd, input logic exc);
    op_valid_i = v;
    op_i       = op;
    addr_i     = addr;
    wdata_i    = wd;
    except_i   = exc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Channel-0 load acked in the first BUSY cycle.
  task automatic runLoad(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] expAddr,
                         input logic [31:0] expData);
    nextCycle;
    applyStimulus(1'b1, op, addr, 32'h0, 1'b0);
    mem_rdata_i = {32'h0, word};
    nextCycle;
    mem_ack_i = 2'b01;
    @(negedge clk);
    checkOutput({tag, "_addr"}, mem_addr_o, expAddr);
    checkOutput({tag, "_be"}, {28'h0, mem_be_o}, 32'hF);
    nextCycle;
    mem_ack_i = 2'b00;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'h0, done_o}, 32'h1);
    checkOutput({tag, "_rdata"}, rdata_o, expData);
  endtask

  // Store acked in the first BUSY cycle on the expected channel.
  task automatic runStore(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] expBe,
                          input logic [31:0] expWdata, input logic [1:0] expCh);
    nextCycle;
    applyStimulus(1'b1, op, addr, wd, 1'b0);
    mem_rdata_i = {32'hDEADBEEF, 32'hDEADBEEF};
    nextCycle;
    mem_ack_i = expCh;
    @(negedge clk);
    checkOutput({tag, "_be"}, {28'h0, mem_be_o}, {28'h0, expBe});
    checkOutput({tag, "_wdata"}, mem_wdata_o, expWdata);
    checkOutput({tag, "_we"}, {31'h0, mem_we_o}, 32'h1);
    checkOutput({tag, "_ch"}, {30'h0, mem_ch_o}, {30'h0, expCh});
    nextCycle;
    mem_ack_i = 2'b00;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_done"}, {31'h0, done_o}, 32'h1);
    checkOutput({tag, "_rdata"}, rdata_o, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    mem_ack_i   = 2'b00;
    mem_rdata_i = 64'h0;
    nextCycle;
    nextCycle;
    applyStimulus(1'b1, OP_LW, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rst_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("rst_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("rst_done", {31'h0, done_o}, 32'h0);
    checkOutput("rst_rdata", rdata_o, 32'h0);

    // LB at offset 3, accepted in the first cycle after reset release
    nextCycle;
    rst = 1'b0;
    applyStimulus(1'b1, OP_LB, 32'h0000_0003, 32'h0, 1'b0);
    mem_rdata_i = {32'h0, 32'h80AA_BBCC};
    @(negedge clk);
    checkOutput("lb_accept_stall", {31'h0, stall_o}, 32'h1);
    checkOutput("lb_accept_req", {31'h0, mem_req_o}, 32'h0);
    nextCycle;
    mem_ack_i = 2'b01;
    @(negedge clk);
    checkOutput("lb_busy_req", {31'h0, mem_req_o}, 32'h1);
    checkOutput("lb_busy_addr", mem_addr_o, 32'h0);
    checkOutput("lb_busy_we", {31'h0, mem_we_o}, 32'h0);
    checkOutput("lb_busy_ch", {30'h0, mem_ch_o}, 32'h1);
    checkOutput("lb_busy_done", {31'h0, done_o}, 32'h0);
    nextCycle;
    mem_ack_i = 2'b00;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lb_done", {31'h0, done_o}, 32'h1);
    checkOutput("lb_rdata", rdata_o, 32'hFFFF_FF80);
    checkOutput("lb_done_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("lb_done_req", {31'h0, mem_req_o}, 32'h0);
    nextCycle;
    @(negedge clk);
    checkOutput("lb_after_done", {31'h0, done_o}, 32'h0);

    // SH on channel 1; a stray channel-0 ack must be ignored
    nextCycle;
    applyStimulus(1'b1, OP_SH, 32'h4000_0002, 32'h1234_BEEF, 1'b0);
    mem_rdata_i = {32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    checkOutput("sh_accept_stall", {31'h0, stall_o}, 32'h1);
    nextCycle;
    mem_ack_i = 2'b01;
    @(negedge clk);
    checkOutput("sh_ch", {30'h0, mem_ch_o}, 32'h2);
    checkOutput("sh_be", {28'h0, mem_be_o}, 32'hC);
    checkOutput("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    checkOutput("sh_we", {31'h0, mem_we_o}, 32'h1);
    checkOutput("sh_addr", mem_addr_o, 32'h4000_0000);
    nextCycle;
    mem_ack_i = 2'b00;
    @(negedge clk);
    checkOutput("sh_wrong_ack_ignored", {31'h0, mem_req_o}, 32'h1);
    nextCycle;
    mem_ack_i = 2'b10;
    @(negedge clk);
    checkOutput("sh_busy3_done", {31'h0, done_o}, 32'h0);
    nextCycle;
    mem_ack_i = 2'b00;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("sh_done", {31'h0, done_o}, 32'h1);
    checkOutput("sh_rdata", rdata_o, 32'h0);
    checkOutput("sh_done_we", {31'h0, mem_we_o}, 32'h0);

    // Misaligned accesses and exception masking
    nextCycle;
    applyStimulus(1'b1, OP_LW, 32'h0000_0006, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lw_mis_adel", {31'h0, adel_o}, 32'h1);
    checkOutput("lw_mis_ades", {31'h0, ades_o}, 32'h0);
    checkOutput("lw_mis_stall", {31'h0, stall_o}, 32'h0);
    nextCycle;
    applyStimulus(1'b1, OP_LH, 32'h0000_0001, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("lw_mis_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("lh_mis_adel", {31'h0, adel_o}, 32'h1);
    nextCycle;
    applyStimulus(1'b1, OP_SW, 32'h0000_0002, 32'h55, 1'b0);
    @(negedge clk);
    checkOutput("sw_mis_ades", {31'h0, ades_o}, 32'h1);
    checkOutput("sw_mis_adel", {31'h0, adel_o}, 32'h0);
    nextCycle;
    applyStimulus(1'b1, OP_SW, 32'h0000_0002, 32'h55, 1'b1);
    @(negedge clk);
    checkOutput("sw_mis_exc_ades", {31'h0, ades_o}, 32'h0);
    nextCycle;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mis_idle_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("mis_idle_we", {31'h0, mem_we_o}, 32'h0);

    // Timeout: no ack for 15 BUSY cycles, op held on the inputs throughout
    nextCycle;
    applyStimulus(1'b1, OP_LW, 32'h0000_0008, 32'h0, 1'b0);
    mem_rdata_i = {32'h0, 32'h1111_1111};
    @(negedge clk);
    checkOutput("to_accept_stall", {31'h0, stall_o}, 32'h1);
    for (int i = 0; i < 15; i++) begin
      nextCycle;
      @(negedge clk);
      checkOutput("to_busy_req", {31'h0, mem_req_o}, 32'h1);
      checkOutput("to_busy_timeout", {31'h0, timeout_o}, 32'h0);
    end
    nextCycle;
    @(negedge clk);
    checkOutput("to_pulse", {31'h0, timeout_o}, 32'h1);
    checkOutput("to_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("to_done", {31'h0, done_o}, 32'h0);
    checkOutput("to_stall", {31'h0, stall_o}, 32'h0);
    nextCycle;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("to_clear", {31'h0, timeout_o}, 32'h0);
    checkOutput("to_no_retry", {31'h0, mem_req_o}, 32'h0);

    // Load extraction table
    runLoad("lhu_hi", OP_LHU, 32'h0000_0002, 32'h8001_0000, 32'h0, 32'h0000_8001);
    runLoad("lh_hi",  OP_LH,  32'h0000_0002, 32'h8001_0000, 32'h0, 32'hFFFF_8001);
    runLoad("lh_lo",  OP_LH,  32'h0000_0000, 32'h0001_7FFE, 32'h0, 32'h0000_7FFE);
    runLoad("lbu_b1", OP_LBU, 32'h0000_0001, 32'h80AA_BBCC, 32'h0, 32'h0000_00BB);
    runLoad("lb_b2",  OP_LB,  32'h0000_0012, 32'h007F_0000, 32'h10, 32'h0000_007F);
    runLoad("lw_w",   OP_LW,  32'h0000_0004, 32'hCAFE_F00D, 32'h4, 32'hCAFE_F00D);

    // Store steering table
    runStore("sb_b1", OP_SB, 32'h0000_0001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 2'b01);
    runStore("sb_b3", OP_SB, 32'h4000_0003, 32'hFFFF_FF81, 4'b1000, 32'h8181_8181, 2'b10);
    runStore("sh_lo", OP_SH, 32'h0000_0000, 32'hABCD_1234, 4'b0011, 32'h1234_1234, 2'b01);
    runStore("sw_ch1", OP_SW, 32'h4000_0004, 32'h0123_4567, 4'b1111, 32'h0123_4567, 2'b10);

    // Ack on the last allowed BUSY cycle beats the timeout
    nextCycle;
    applyStimulus(1'b1, OP_LW, 32'h0000_0000, 32'h0, 1'b0);
    mem_rdata_i = {32'h0, 32'h0BAD_F00D};
    for (int i = 0; i < 14; i++) nextCycle;
    nextCycle;
    mem_ack_i = 2'b01;
    @(negedge clk);
    checkOutput("prio_req", {31'h0, mem_req_o}, 32'h1);
    nextCycle;
    mem_ack_i = 2'b00;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("prio_done", {31'h0, done_o}, 32'h1);
    checkOutput("prio_timeout", {31'h0, timeout_o}, 32'h0);
    checkOutput("prio_rdata", rdata_o, 32'h0BAD_F00D);

    // Reset in the second BUSY cycle, then a late ack
    nextCycle;
    applyStimulus(1'b1, OP_SW, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    nextCycle;
    nextCycle;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstb_req_before", {31'h0, mem_req_o}, 32'h1);
    nextCycle;
    rst = 1'b0;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    mem_ack_i = 2'b01;
    @(negedge clk);
    checkOutput("rstb_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("rstb_we", {31'h0, mem_we_o}, 32'h0);
    checkOutput("rstb_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("rstb_done", {31'h0, done_o}, 32'h0);
    checkOutput("rstb_timeout", {31'h0, timeout_o}, 32'h0);
    checkOutput("rstb_ch", {30'h0, mem_ch_o}, 32'h0);
    checkOutput("rstb_be", {28'h0, mem_be_o}, 32'h0);
    nextCycle;
    mem_ack_i = 2'b00;
    @(negedge clk);
    checkOutput("rstb_late_done", {31'h0, done_o}, 32'h0);

    // SW under a pending exception is discarded
    nextCycle;
    applyStimulus(1'b1, OP_SW, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checkOutput("exc_stall", {31'h0, stall_o}, 32'h0);
    nextCycle;
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("exc_req", {31'h0, mem_req_o}, 32'h0);
    checkOutput("exc_we", {31'h0, mem_we_o}, 32'h0);

    nextCycle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter NUM_CH, default 2: number of memory/peripheral channels; power of two, at least 2.
REQ-002 Parameter CH_SEL_MSB, default 30: MSB of the address field addr_i[CH_SEL_MSB -: log2(NUM_CH)] that selects the channel.
REQ-003 Parameter TIMEOUT_CYC, default 15: maximum number of BUSY cycles without an ack before the access aborts; range 1 to 255.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 op_valid_i  in  1  a memory operation is present this cycle.
REQ-007 op_i  in  4  operation: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW; encodings are defined in mem_pkg.
REQ-008 addr_i  in  32  byte address.
REQ-009 wdata_i  in  32  store source register value.
REQ-010 except_i  in  1  an upstream exception is pending; the operation SHALL be discarded.
REQ-011 stall_o  out  1  holds the upstream pipeline.
REQ-012 done_o  out  1  one-cycle pulse when an access completes normally.
REQ-013 rdata_o  out  32  aligned and extended load result; valid only while done_o is high.
REQ-014 adel_o / ades_o  out  1 each  misaligned load / misaligned store pulse.
REQ-015 timeout_o  out  1  pulse when an access aborts on timeout.
REQ-016 mem_req_o, mem_we_o  out  1 each  request and write strobe, shared by all channels.
REQ-017 mem_ch_o  out  NUM_CH  one-hot channel select.
REQ-018 mem_addr_o  out  32  word address; bits [1:0] forced to 0.
REQ-019 mem_be_o  out  4  byte enables, little-endian.
REQ-020 mem_wdata_o  out  32  lane-replicated store data.
REQ-021 mem_ack_i  in  NUM_CH  per-channel acknowledge.
REQ-022 mem_rdata_i  in  32*NUM_CH  per-channel read data, flattened; channel k occupies bits [32k+31:32k].

Function
REQ-023 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-024 Accept condition: in IDLE with op_valid_i=1, op_i not NONE, except_i=0 and the address aligned; the request fields are registered and the FSM moves to BUSY.
REQ-025 stall_o SHALL be 1 in the accept cycle and throughout BUSY, and 0 in IDLE otherwise and in DONE.
REQ-026 In BUSY: mem_req_o=1, with mem_ch_o, mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stable from the registered copy.
REQ-027 Only mem_ack_i of the selected channel is honoured; ack bits of other channels, and any ack outside BUSY, are ignored.
REQ-028 An ack seen in the first BUSY cycle completes the access, so minimum latency is accept, then BUSY, then DONE: done_o rises 2 cycles after accept.
REQ-029 On an ack cycle, the FSM moves to DONE and the selected channel's data is captured.
REQ-030 In DONE: done_o=1, rdata_o is driven (0 for stores), mem_req_o=0; next state is IDLE unconditionally.
REQ-031 New operations are accepted only in IDLE, so there is no back-to-back overlap.
REQ-032 Load extraction uses byte offset o=addr[1:0].
REQ-033 LB/LBU take byte o, sign- or zero-extended.
REQ-034 LH/LHU take halfword o[1], sign- or zero-extended.
REQ-035 LW takes the whole word.
REQ-036 Store enables: SB gives mem_be_o = 1<<o with the byte replicated on all 4 lanes.
REQ-037 SH gives mem_be_o = 0011 or 1100, with the halfword replicated on both halves.
REQ-038 SW gives mem_be_o = 1111.
REQ-039 For loads, mem_be_o=1111 and mem_we_o=0.
REQ-040 Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
REQ-041 A misaligned operation SHALL pulse adel_o (loads) or ades_o (stores) in the same cycle, with no request, no stall, and the FSM staying in IDLE.
REQ-042 except_i=1 in IDLE SHALL suppress acceptance and the misalignment flags; a discarded store SHALL never reach mem_we_o.
REQ-043 Timeout: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without an ack.
REQ-044 When the timeout counter reaches TIMEOUT_CYC-1 without an ack, the next cycle SHALL be IDLE with timeout_o=1 for one cycle, mem_req_o=0, done_o=0, and stall_o=0 in that cycle.
REQ-045 An ack in the same cycle the counter reaches TIMEOUT_CYC-1 SHALL complete the access normally; the ack takes priority over the timeout.
REQ-046 The channel index decodes from the address; every index value is legal, so no decode error exists.

Reset
REQ-047 rst=1 SHALL force the FSM to IDLE and the counter to 0.
REQ-048 rst=1 SHALL force every output to 0 on the next edge, including in mid-BUSY, which drops mem_req_o with no done_o and no timeout_o.
REQ-049 After rst falls, the first acceptance is possible in the following cycle.

Structure
REQ-050 Package mem_pkg SHALL hold the op_i encodings, the FSM state enumeration and the default parameter constants.
REQ-051 One sub-module, mem_lane_align, SHALL provide the combinational store byte-enable/replication and load extract/extend functions.
REQ-052 mem_access SHALL hold the FSM, the counter, the channel decode and the registers.

Verification
REQ-053 Basic load: LB at addr 0x0000_0003 on channel 0, mem_rdata 0x80AA_BBCC, ack in the first BUSY cycle -> rdata_o=0xFFFF_FF80 and done_o 2 cycles after accept.
REQ-054 Channel store: SH at 0x4000_0002 with wdata 0x1234_BEEF -> mem_ch_o=10, mem_be_o=1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o=1; ack on channel 1 after 3 cycles -> done_o pulse, and no write on channel 0.
REQ-055 Misaligned load: LW at 0x0000_0006 -> adel_o pulse, mem_req_o stays 0, stall_o=0.
REQ-056 Timeout: no ack with TIMEOUT_CYC=15 -> timeout_o pulses 15 cycles after BUSY entry; a subsequent LHU at 0x2 with data 0x8001_0000 -> rdata_o=0x0000_8001.
REQ-057 Reset and exception: rst asserted in the 2nd BUSY cycle -> all outputs 0 next edge, and a later ack is ignored; SW with except_i=1 -> no request.
